// File: rtl/mult_n_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_n_seq_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    // Bits needed to hold an iteration count from 0 to width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_n_seq_if.sv
// Operand/result bundle between a requester and the multiplier.
interface mult_n_seq_if #(
    parameter int unsigned WIDTH = mult_n_seq_pkg::DefaultWidth
);
    logic               init;
    logic               signed_mode;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] pp;
    logic               busy;
    logic               done;

    modport master (
        output init, signed_mode, A, B,
        input  pp, busy, done
    );

    modport slave (
        input  init, signed_mode, A, B,
        output pp, busy, done
    );
endinterface

// File: rtl/mult_n_seq_ctrl.sv
// Sequencing FSM and iteration counter; owns the busy/done flags.
module mult_n_seq_ctrl import mult_n_seq_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   init_i,
    output logic   start_o,
    output state_e state_o,
    output logic   busy_o,
    output logic   done_o
);
    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next state: accept init only when idle or holding a result; CALC runs exactly WIDTH edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        start_o = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (init_i) begin
                    start_o = 1'b1;
                    state_d = StCalc;
                    cnt_d   = CntW'(WIDTH);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/mult_n_seq.sv
// Fixed-latency sequential shift-add multiplier, signed (sign-magnitude) or unsigned.
module mult_n_seq import mult_n_seq_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_n_seq_if.slave bus
);
    localparam int unsigned ProdW = 2 * WIDTH;

    state_e state;
    logic   start;
    logic   busy;
    logic   done;

    logic [ProdW-1:0] acc_q, acc_d;
    logic [ProdW-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [ProdW-1:0] pp_q, pp_d;
    logic [WIDTH-1:0] a_mag, b_mag;

    mult_n_seq_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (bus.init),
        .start_o (start),
        .state_o (state),
        .busy_o  (busy),
        .done_o  (done)
    );

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned pattern.
    always_comb begin
        a_mag = (bus.signed_mode && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
        b_mag = (bus.signed_mode && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
    end

    // Datapath next state: load on start, shift-add in CALC, apply sign in FIX.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        pp_d     = pp_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        end else if (state == StCalc) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
        end else if (state == StFix) begin
            // Negating zero yields zero, so no negative-zero special case is needed.
            pp_d = neg_q ? (~acc_q + ProdW'(1)) : acc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            pp_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            pp_q     <= pp_d;
        end
    end

    assign bus.pp   = pp_q;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: tb/tb_mult_n_seq.sv
// Scoreboard bench: drivers queue expected products, monitors check on each done rise.
module tb_mult_n_seq;

    typedef struct {
        logic [15:0] pp;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q4[$];
    exp_t q8[$];
    logic done4_prev;
    logic done8_prev;

    mult_n_seq_if #(.WIDTH(4)) bus4 ();
    mult_n_seq_if #(.WIDTH(8)) bus8 ();

    mult_n_seq #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mult_n_seq #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the WIDTH=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (bus4.busy && bus4.done) begin
                errors++;
                $display("FAIL w4_busy_done_overlap at cycle %0d", cyc);
            end
            if (bus4.done && !done4_prev) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL w4_unexpected_done: pp=%0h at cycle %0d", bus4.pp, cyc);
                end else begin
                    e = q4.pop_front();
                    if (bus4.pp !== e.pp[7:0] || cyc != e.due) begin
                        errors++;
                        $display("FAIL w4_result: pp=%0h cycle=%0d expected pp=%0h cycle=%0d",
                                 bus4.pp, cyc, e.pp[7:0], e.due);
                    end
                end
            end
        end
        done4_prev = bus4.done;
    end

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (bus8.busy && bus8.done) begin
                errors++;
                $display("FAIL w8_busy_done_overlap at cycle %0d", cyc);
            end
            if (bus8.done && !done8_prev) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL w8_unexpected_done: pp=%0h at cycle %0d", bus8.pp, cyc);
                end else begin
                    e = q8.pop_front();
                    if (bus8.pp !== e.pp || cyc != e.due) begin
                        errors++;
                        $display("FAIL w8_result: pp=%0h cycle=%0d expected pp=%0h cycle=%0d",
                                 bus8.pp, cyc, e.pp, e.due);
                    end
                end
            end
        end
        done8_prev = bus8.done;
    end

    task automatic wait_done4();
        int n = 0;
        while (!bus4.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus4.done) begin
            checks++;
            errors++;
            $display("FAIL w4_timeout: done=%0b expected 1", bus4.done);
        end
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!bus8.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.done) begin
            checks++;
            errors++;
            $display("FAIL w8_timeout: done=%0b expected 1", bus8.done);
        end
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] exp);
        exp_t e;
        @(negedge clk);
        bus4.A           = a;
        bus4.B           = b;
        bus4.signed_mode = s;
        bus4.init        = 1'b1;
        e.pp             = {8'h00, exp};
        e.due            = cyc + 6;
        q4.push_back(e);
        @(negedge clk);
        bus4.init = 1'b0;
        wait_done4();
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp);
        exp_t e;
        @(negedge clk);
        bus8.A           = a;
        bus8.B           = b;
        bus8.signed_mode = s;
        bus8.init        = 1'b1;
        e.pp             = exp;
        e.due            = cyc + 10;
        q8.push_back(e);
        @(negedge clk);
        bus8.init = 1'b0;
        wait_done8();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        int dcount;
        exp_t e;
        cyc = 0;
        checks = 0;
        errors = 0;
        done4_prev = 1'b0;
        done8_prev = 1'b0;
        bus4.init = 1'b0; bus4.signed_mode = 1'b0; bus4.A = '0; bus4.B = '0;
        bus8.init = 1'b0; bus8.signed_mode = 1'b0; bus8.A = '0; bus8.B = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_pp", 32'(bus4.pp), 32'h0);
        check("reset_busy", 32'(bus4.busy), 32'h0);
        check("reset_done", 32'(bus4.done), 32'h0);
        check("reset_pp_w8", 32'(bus8.pp), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 3*3 with init held for two cycles: second high sample must be ignored.
        @(negedge clk);
        bus4.A = 4'd3; bus4.B = 4'd3; bus4.signed_mode = 1'b0; bus4.init = 1'b1;
        e.pp = 16'h0009; e.due = cyc + 6;
        q4.push_back(e);
        busy_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (!bus4.busy) break;
            busy_cnt++;
            @(negedge clk);
            bus4.init = 1'b0;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd5);
        check("done_after_busy", 32'(bus4.done), 32'h1);
        check("pp_3x3", 32'(bus4.pp), 32'h09);
        repeat (3) @(negedge clk);
        check("done_held", 32'(bus4.done), 32'h1);
        check("pp_held", 32'(bus4.pp), 32'h09);
        check("busy_low_held", 32'(bus4.busy), 32'h0);

        // Directed WIDTH=4 vectors.
        go4(4'hF, 4'hF, 1'b0, 8'hE1);
        go4(4'h0, 4'h9, 1'b0, 8'h00);
        go4(4'h8, 4'h7, 1'b1, 8'hC8);
        go4(4'h8, 4'h8, 1'b1, 8'h40);
        go4(4'hF, 4'h1, 1'b1, 8'hFF);
        go4(4'h0, 4'hD, 1'b1, 8'h00);
        go4(4'h3, 4'hE, 1'b1, 8'hFA);
        go4(4'h8, 4'h8, 1'b0, 8'h40);

        // Init held high for 20 cycles; A churns while CALC runs.
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0 && bus4.done) dcount++;
            bus4.init = 1'b1;
            bus4.signed_mode = 1'b0;
            bus4.B = 4'd3;
            if (i % 6 == 0) begin
                bus4.A = 4'(i / 6 + 2);
                e.pp = 16'((i / 6 + 2) * 3);
                e.due = cyc + 6;
                q4.push_back(e);
            end else begin
                bus4.A = 4'($urandom);
            end
        end
        @(negedge clk);
        bus4.init = 1'b0;
        check("b2b_done_cycles", 32'(dcount), 32'd3);
        wait_done4();
        check("b2b_last_pp", 32'(bus4.pp), 32'h0F);

        // Reset during the second CALC cycle abandons the operation.
        @(negedge clk);
        bus4.A = 4'd7; bus4.B = 4'd7; bus4.signed_mode = 1'b0; bus4.init = 1'b1;
        @(negedge clk);
        bus4.init = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_pp", 32'(bus4.pp), 32'h0);
        check("midop_reset_busy", 32'(bus4.busy), 32'h0);
        check("midop_reset_done", 32'(bus4.done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_reset", 32'(bus4.done), 32'h0);
        check("no_busy_after_reset", 32'(bus4.busy), 32'h0);
        go4(4'd5, 4'd6, 1'b0, 8'h1E);

        // Directed WIDTH=8 vectors.
        go8(8'h80, 8'h80, 1'b1, 16'h4000);
        go8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        go8(8'hFF, 8'h02, 1'b1, 16'hFFFE);
        go8(8'h80, 8'h02, 1'b0, 16'h0100);
        go8(8'h00, 8'h85, 1'b1, 16'h0000);

        repeat (3) @(negedge clk);
        check("queue4_drained", 32'(q4.size()), 32'd0);
        check("queue8_drained", 32'(q8.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_n_seq.md
MULT_N_SEQ -- requirements
Module: mult_n_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width; legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 init  input  1  start request, level-sampled at the rising edge.
REQ-005 signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; sampled with init.
REQ-006 A  input  WIDTH  multiplicand, sampled with init.
REQ-007 B  input  WIDTH  multiplier, sampled with init.
REQ-008 pp  output  2*WIDTH  registered product.
REQ-009 busy  output  1  high while a multiplication is in progress.
REQ-010 done  output  1  high while pp holds a valid result.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-012 In IDLE or DONE, init=1 at edge k SHALL latch A, B and signed_mode, clear the accumulator, load the counter with WIDTH, clear done, set busy and enter CALC.
REQ-013 When signed_mode=1, operands SHALL be latched as WIDTH-bit unsigned magnitudes with the result sign = sign(A) XOR sign(B); the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1).
REQ-014 Each CALC edge SHALL add the shifted multiplicand to the 2*WIDTH accumulator if the multiplier LSB is 1, then shift the multiplier right and the multiplicand left by one, and decrement the counter.
REQ-015 CALC SHALL last exactly WIDTH edges (k+1..k+WIDTH) regardless of operand values; there is no early termination.
REQ-016 The FIX edge (k+WIDTH+1) SHALL write pp = accumulator, negated when the result sign is 1, then set done=1, clear busy and enter DONE.
REQ-017 Latency SHALL be fixed: done rises WIDTH+1 cycles after the init-sampling edge.
REQ-018 In DONE, pp and done SHALL hold until the next accepted init or reset.
REQ-019 init SHALL be ignored in CALC and FIX; a held-high init SHALL NOT abort or restart an operation.
REQ-020 If init is still high in DONE, a new operation SHALL start at that edge (back-to-back); done drops on that same edge.
REQ-021 Unsigned products SHALL be exact in 2*WIDTH bits.
REQ-022 Signed products SHALL be exact 2*WIDTH-bit two's complement, including (-2^(WIDTH-1))^2.
REQ-023 A zero operand SHALL still take the full latency and produce pp=0 with no negative zero.
REQ-024 busy and done SHALL never be high simultaneously.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, pp=0, busy=0, done=0 and clear the accumulator, counter and operand registers.
REQ-026 Reset asserted mid-operation SHALL abandon the operation; no done pulse follows release.
REQ-027 After rst_n deasserts, the first init SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-028 Package mult_n_seq_pkg SHALL hold the state enumeration, the default WIDTH and the counter-width function clog2(WIDTH+1).
REQ-029 The datapath (accumulator, shift registers, negation) and the FSM SHALL share one module; the optional sub-module mult_n_seq_ctrl holds only the FSM and counter.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 WIDTH=4, unsigned, A=3, B=3, init pulsed for 2 cycles -> busy for 5 cycles, then pp=0x09 and done=1, held; single operation only.
REQ-032 WIDTH=4, unsigned, A=15, B=15 -> pp=0xE1; A=0, B=9 -> pp=0x00, still after 5 cycles.
REQ-033 WIDTH=4, signed: A=-8, B=7 -> pp=0xC8 (-56); A=-8, B=-8 -> pp=0x40; A=-1, B=1 -> pp=0xFF.
REQ-034 WIDTH=8, signed, A=0x80, B=0x80 -> pp=0x4000; unsigned A=0xFF, B=0xFF -> pp=0xFE01 after 9 cycles.
REQ-035 Reset: assert rst_n=0 at CALC cycle 2 -> pp=0, busy=0, done=0 immediately; then init with A=5, B=6 (WIDTH=4) -> pp=0x1E.
REQ-036 Init held high continuously for 20 cycles (WIDTH=4) -> back-to-back operations with done high for 1 cycle every 6 cycles; toggling A mid-CALC does not change the result.
